// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: operation codes, FSM states, helpers.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_ILL  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_AND  = 4'b0100,
    OP_EQ   = 4'b0101,
    OP_NEQ  = 4'b0110,
    OP_MUL  = 4'b0111,
    OP_DIVU = 4'b1000,
    OP_REMU = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ops that run through the iterative datapath instead of the combinational one.
  function automatic logic is_iter(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: LSB-first shift-add multiply and restoring unsigned divide.
// Ports: load (capture a/b, clear counter), step (one iteration), op (selects
// mul/div behaviour and result), last (current step is the final one), result.
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] result
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  // acc: product (MUL) or partial remainder (DIV).
  // sh : multiplier shifting right (MUL) or dividend -> quotient shifting left (DIV).
  // opb: multiplicand shifting left (MUL) or fixed divisor (DIV).
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q,  sh_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;

  // Next-state for the iteration registers.
  always_comb begin
    acc_d   = acc_q;
    sh_d    = sh_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    trial   = {acc_q, sh_q[WIDTH-1]};
    fits    = (trial >= {1'b0, opb_q});
    // When the trial fits, the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    rem_sub = trial[WIDTH-1:0] - opb_q;

    if (load) begin
      acc_d = '0;
      sh_d  = a;
      opb_d = b;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (op == OP_MUL) begin
        if (sh_q[0]) acc_d = acc_q + opb_q;
        sh_d  = sh_q >> 1;
        opb_d = opb_q << 1;
      end else begin
        // Divide by zero falls out naturally: every trial fits, so the quotient
        // becomes all ones and the remainder ends up equal to the dividend.
        if (fits) begin
          acc_d = rem_sub;
          sh_d  = {sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = trial[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // Iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

  assign last   = (cnt_q == CNT_W'(WIDTH - 1));
  assign result = (op == OP_DIVU) ? sh_q : acc_q;

endmodule

// File: rtl/alu_multiciclo.sv
// Multicycle ALU: single-cycle ADD/SUB/OR/AND/EQ/NEQ plus iterative MUL/DIVU/REMU
// behind a start/done handshake.
// Ports: clk, rst_n (async active-low), start, ALUControl (op code), ALUSrcA/B
// (operands sampled with start), ALUResult/Zero (registered, held), busy, done.
module alu_multiciclo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ALU_CTRL_W-1:0] ALUControl,
  input  logic [WIDTH-1:0]      ALUSrcA,
  input  logic [WIDTH-1:0]      ALUSrcB,
  output logic [WIDTH-1:0]      ALUResult,
  output logic                  Zero,
  output logic                  busy,
  output logic                  done
);

  state_t           state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  alu_op_t          op_in;
  logic             core_load, core_step, core_last;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] simple_res;

  assign op_in = alu_op_t'(ALUControl);

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .step   (core_step),
    .op     (op_q),
    .a      (ALUSrcA),
    .b      (ALUSrcB),
    .last   (core_last),
    .result (core_result)
  );

  // Single-cycle ops on the latched operands; illegal codes give 0.
  always_comb begin
    simple_res = '0;
    case (op_q)
      OP_ADD:  simple_res = a_q + b_q;
      OP_SUB:  simple_res = a_q - b_q;
      OP_OR:   simple_res = a_q | b_q;
      OP_AND:  simple_res = a_q & b_q;
      OP_EQ:   simple_res = WIDTH'(a_q == b_q);
      OP_NEQ:  simple_res = WIDTH'(a_q != b_q);
      default: simple_res = '0;
    endcase
  end

  // Control FSM next-state and output logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op_in;
          a_d  = ALUSrcA;
          b_d  = ALUSrcB;
          if (is_iter(op_in)) begin
            core_load = 1'b1;
            state_d   = CALC;
          end else begin
            state_d = DONE;
          end
        end
      end
      CALC: begin
        core_step = 1'b1;
        if (core_last) state_d = DONE;
      end
      DONE: begin
        // Result, Zero and done all register on the edge leaving DONE.
        result_d = is_iter(op_q) ? core_result : simple_res;
        zero_d   = (result_d == '0);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ILL;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
